// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the data-memory arbiter:
//               FSM state encoding and requester identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    // Arbiter FSM states; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    // Requester identifiers.
    localparam logic REQ_PIPE = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

    // The requester that is not 'id'; used to hand round-robin priority over.
    function automatic logic other_req(input logic id);
        return ~id;
    endfunction

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter sharing one single-port synchronous data
//               memory between the pipeline MEM stage (port 0) and the
//               loader/debug port (port 1), with a bounded exclusive lock for
//               bursts and one-cycle read-response routing.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    // requester 0: pipeline MEM stage
    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic                  p0_lock,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    // requester 1: loader/debug port
    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic                  p1_lock,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    // memory side
    output logic                  mem_MemWrite,
    output logic                  mem_MemRead,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    localparam int                 c_cnt_w     = $clog2(MAX_BURST + 1);
    localparam logic [c_cnt_w-1:0] c_max_burst = c_cnt_w'(MAX_BURST);
    localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic               r_rr_ptr;
    logic               w_rr_nxt;
    logic [c_cnt_w-1:0] r_burst_cnt;
    logic [c_cnt_w-1:0] w_burst_nxt;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic               w_grant0;
    logic               w_grant1;
    logic               w_rd_accept;

    // Grant selection; nothing is granted while reset is asserted so the
    // memory sees no enable during the reset cycle.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!reset) begin
            case (r_state)
                ARB: begin
                    w_grant0 = p0_valid && (!p1_valid || r_rr_ptr == REQ_PIPE);
                    w_grant1 = p1_valid && (!p0_valid || r_rr_ptr == REQ_LOAD);
                end
                LOCK0:   w_grant0 = p0_valid;
                LOCK1:   w_grant1 = p1_valid;
                default: ;
            endcase
        end
    end

    // Next-state logic for the FSM, round-robin pointer and burst counter.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_burst_nxt = r_burst_cnt;
        case (r_state)
            ARB: begin
                if (w_grant0) begin
                    w_rr_nxt = other_req(REQ_PIPE);
                    if (p0_lock) begin
                        w_state_nxt = LOCK0;
                        w_burst_nxt = c_one;
                    end
                end else if (w_grant1) begin
                    w_rr_nxt = other_req(REQ_LOAD);
                    if (p1_lock) begin
                        w_state_nxt = LOCK1;
                        w_burst_nxt = c_one;
                    end
                end
            end
            // The counter runs whether or not the owner issues a beat; the
            // cycle that drops lock is still exclusive to the owner.
            LOCK0: begin
                w_burst_nxt = r_burst_cnt + c_one;
                if (!p0_lock || r_burst_cnt >= c_max_burst) begin
                    w_state_nxt = ARB;
                    w_rr_nxt    = other_req(REQ_PIPE);
                end
            end
            LOCK1: begin
                w_burst_nxt = r_burst_cnt + c_one;
                if (!p1_lock || r_burst_cnt >= c_max_burst) begin
                    w_state_nxt = ARB;
                    w_rr_nxt    = other_req(REQ_LOAD);
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    // FSM, pointer and burst-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ARB;
            r_rr_ptr    <= REQ_PIPE;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    assign w_rd_accept = (w_grant0 && !p0_we) || (w_grant1 && !p1_we);

    // One-entry tracker remembering who owns the read data returning next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= REQ_PIPE;
        end else begin
            r_rsp_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_rsp_id <= w_grant1 ? REQ_LOAD : REQ_PIPE;
            end
        end
    end

    // Memory drive muxed from the granted port; all zero when idle.
    always_comb begin
        mem_MemWrite   = 1'b0;
        mem_MemRead    = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        if (w_grant0) begin
            mem_MemWrite   = p0_we;
            mem_MemRead    = !p0_we;
            mem_address    = p0_addr;
            mem_write_data = p0_wdata;
        end else if (w_grant1) begin
            mem_MemWrite   = p1_we;
            mem_MemRead    = !p1_we;
            mem_address    = p1_addr;
            mem_write_data = p1_wdata;
        end
    end

    assign p0_ready = w_grant0;
    assign p1_ready = w_grant1;

    // A response pending when reset arrives is dropped, not delivered.
    assign p0_rvalid = !reset && r_rsp_valid && (r_rsp_id == REQ_PIPE);
    assign p1_rvalid = !reset && r_rsp_valid && (r_rsp_id == REQ_LOAD);
    assign p0_rdata  = p0_rvalid ? mem_read_data : '0;
    assign p1_rdata  = p1_rvalid ? mem_read_data : '0;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter with a behavioural
//               single-port synchronous memory and a read-response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 8;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          p0_valid, p0_ready, p0_we, p0_lock, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_valid, p1_ready, p1_we, p1_lock, p1_rvalid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic          mem_MemWrite, mem_MemRead;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data, mem_read_data;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q0[$];
    exp_t q1[$];

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(16)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .p0_valid      (p0_valid),
        .p0_ready      (p0_ready),
        .p0_we         (p0_we),
        .p0_addr       (p0_addr),
        .p0_wdata      (p0_wdata),
        .p0_lock       (p0_lock),
        .p0_rvalid     (p0_rvalid),
        .p0_rdata      (p0_rdata),
        .p1_valid      (p1_valid),
        .p1_ready      (p1_ready),
        .p1_we         (p1_we),
        .p1_addr       (p1_addr),
        .p1_wdata      (p1_wdata),
        .p1_lock       (p1_lock),
        .p1_rvalid     (p1_rvalid),
        .p1_rdata      (p1_rdata),
        .mem_MemWrite  (mem_MemWrite),
        .mem_MemRead   (mem_MemRead),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data)
    );

    always #5 clk = ~clk;

    // Cycle index: inputs driven just after posedge belong to cycle 'cyc'.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port memory with registered read data.
    always @(posedge clk) begin
        if (mem_MemWrite) mem[mem_address] <= mem_write_data;
        if (mem_MemRead)  mem_read_data    <= mem[mem_address];
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_bus(input string name, input logic r0, input logic r1, input logic we,
                             input logic re, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        chk({name, "_ready"}, {30'd0, p0_ready, p1_ready}, {30'd0, r0, r1});
        chk({name, "_en"},    {30'd0, mem_MemWrite, mem_MemRead}, {30'd0, we, re});
        chk({name, "_addr"},  {24'd0, mem_address}, {24'd0, addr});
        chk({name, "_wdata"}, mem_write_data, wd);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic set_p0(input logic v, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic l);
        p0_valid = v; p0_we = we; p0_addr = a; p0_wdata = d; p0_lock = l;
    endtask

    task automatic set_p1(input logic v, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic l);
        p1_valid = v; p1_we = we; p1_addr = a; p1_wdata = d; p1_lock = l;
    endtask

    // Expected read data for a read accepted in the current cycle.
    task automatic expect_rd(input int port, input logic [DW-1:0] d);
        exp_t e;
        e.data = d;
        e.due  = cyc + 1;
        if (port == 0) q0.push_back(e);
        else           q1.push_back(e);
    endtask

    // Scoreboard monitor for one port: a due entry must be delivered exactly
    // now; outside of that the port must show rvalid=0 and rdata=0.
    task automatic mon(input int port, input logic rv, input logic [DW-1:0] rd);
        exp_t e;
        logic have;
        have = (port == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) e = (port == 0) ? q0[0] : q1[0];
        if (have && e.due <= cyc) begin
            if (port == 0) void'(q0.pop_front());
            else           void'(q1.pop_front());
            n_checks++;
            if (e.due == cyc && rv === 1'b1 && rd === e.data) n_pass++;
            else $display("FAIL rsp_p%0d: rvalid=%b rdata=%h expected rvalid=1 rdata=%h at cycle %0d (now %0d)",
                          port, rv, rd, e.data, e.due, cyc);
        end else if (rv !== 1'b0 || rd !== '0) begin
            n_checks++;
            $display("FAIL spurious_p%0d: rvalid=%b rdata=%h expected rvalid=0 rdata=0 at cycle %0d",
                     port, rv, rd, cyc);
        end
    endtask

    always @(negedge clk) begin
        mon(0, p0_rvalid, p0_rdata);
        mon(1, p1_rvalid, p1_rdata);
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem_read_data = '0;
        reset = 1'b1;
        set_p0(0, 0, 8'h00, 32'h0, 0);
        set_p1(0, 0, 8'h00, 32'h0, 0);

        // Reset held two cycles; the second has a request that must be ignored.
        tick; settle;
        check_bus("reset1", 0, 0, 0, 0, 8'h00, 32'h0);
        tick; set_p0(1, 1, 8'h10, 32'h12345678, 0); settle;
        check_bus("reset2", 0, 0, 0, 0, 8'h00, 32'h0);
        chk("reset2_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
        tick; reset = 1'b0; set_p0(0, 0, 8'h00, 32'h0, 0); settle;
        check_bus("idle", 0, 0, 0, 0, 8'h00, 32'h0);

        // Contention: both write, p0 wins from reset, p1 next.
        tick;
        set_p0(1, 1, 8'h10, 32'h11111111, 0);
        set_p1(1, 1, 8'h20, 32'h22222222, 0);
        settle; check_bus("cont_w0", 1, 0, 1, 0, 8'h10, 32'h11111111);
        tick; set_p0(1, 0, 8'h10, 32'h0, 0);
        settle; check_bus("cont_w1", 0, 1, 1, 0, 8'h20, 32'h22222222);
        tick; set_p1(1, 0, 8'h20, 32'h0, 0); expect_rd(0, 32'h11111111);
        settle; check_bus("cont_r0", 1, 0, 0, 1, 8'h10, 32'h0);
        tick; expect_rd(1, 32'h22222222);
        settle; check_bus("cont_r1", 0, 1, 0, 1, 8'h20, 32'h0);
        tick; set_p1(0, 0, 8'h00, 32'h0, 0); expect_rd(0, 32'h11111111);
        settle; check_bus("cont_r0b", 1, 0, 0, 1, 8'h10, 32'h0);

        // Write then read on the same address returns the new value.
        tick; set_p0(1, 1, 8'h10, 32'hDEADBEEF, 0);
        settle; check_bus("wr_rd_w", 1, 0, 1, 0, 8'h10, 32'hDEADBEEF);
        tick; set_p0(1, 0, 8'h10, 32'h0, 0); expect_rd(0, 32'hDEADBEEF);
        settle; check_bus("wr_rd_r", 1, 0, 0, 1, 8'h10, 32'h0);
        tick; set_p0(0, 0, 8'h00, 32'h0, 0);
        settle; check_bus("wr_rd_idle", 0, 0, 0, 0, 8'h00, 32'h0);

        // Locked burst of four p1 writes while p0 keeps requesting.
        tick;
        set_p0(1, 1, 8'h30, 32'h0000AAAA, 0);
        set_p1(1, 1, 8'h00, 32'h000000B0, 1);
        settle; check_bus("lock_b0", 0, 1, 1, 0, 8'h00, 32'h000000B0);
        for (int i = 1; i < 4; i++) begin
            tick; set_p1(1, 1, AW'(i), 32'h000000B0 + DW'(i), 1);
            settle; check_bus($sformatf("lock_b%0d", i), 0, 1, 1, 0, AW'(i), 32'h000000B0 + DW'(i));
        end
        tick; set_p1(0, 0, 8'h00, 32'h0, 0);
        settle; check_bus("lock_release", 0, 0, 0, 0, 8'h00, 32'h0);
        tick;
        settle; check_bus("lock_after", 1, 0, 1, 0, 8'h30, 32'h0000AAAA);
        tick; set_p0(0, 0, 8'h00, 32'h0, 0); set_p1(1, 0, 8'h03, 32'h0, 0); expect_rd(1, 32'h000000B3);
        settle; check_bus("burst_rd", 0, 1, 0, 1, 8'h03, 32'h0);
        tick; set_p1(0, 0, 8'h00, 32'h0, 0); set_p0(1, 0, 8'h30, 32'h0, 0); expect_rd(0, 32'h0000AAAA);
        settle; check_bus("p0_rd30", 1, 0, 0, 1, 8'h30, 32'h0);

        // Lock timeout: p1 never drops lock; forced out after 16 LOCK1 cycles.
        tick;
        set_p0(1, 0, 8'h03, 32'h0, 0);
        set_p1(1, 1, 8'h40, 32'h00004040, 1);
        settle; check_bus("lockto_enter", 0, 1, 1, 0, 8'h40, 32'h00004040);
        for (int i = 1; i <= 16; i++) begin
            tick;
            settle; check_bus($sformatf("lockto_l%0d", i), 0, 1, 1, 0, 8'h40, 32'h00004040);
        end
        tick; expect_rd(0, 32'h000000B3);
        settle; check_bus("lockto_exit", 1, 0, 0, 1, 8'h03, 32'h0);
        tick; set_p0(0, 0, 8'h00, 32'h0, 0);
        settle; check_bus("lockto_p1turn", 0, 1, 1, 0, 8'h40, 32'h00004040);
        tick; set_p1(0, 0, 8'h00, 32'h0, 0);
        settle; check_bus("lockto_drop", 0, 0, 0, 0, 8'h00, 32'h0);
        tick;
        settle; check_bus("lockto_idle", 0, 0, 0, 0, 8'h00, 32'h0);

        // Reset with a p1 read in flight and the arbiter in LOCK1.
        tick; set_p1(1, 0, 8'h01, 32'h0, 1);
        settle; check_bus("rst_rd", 0, 1, 0, 1, 8'h01, 32'h0);
        tick; reset = 1'b1; set_p0(1, 1, 8'h50, 32'h00000055, 0);
        settle; check_bus("rst_cycle", 0, 0, 0, 0, 8'h00, 32'h0);
        chk("rst_cycle_rvalid", {31'd0, p1_rvalid}, 32'd0);
        tick; reset = 1'b0;
        settle; check_bus("rst_after", 1, 0, 1, 0, 8'h50, 32'h00000055);
        chk("rst_after_rvalid", {31'd0, p1_rvalid}, 32'd0);
        tick; set_p0(0, 0, 8'h00, 32'h0, 0); set_p1(0, 0, 8'h00, 32'h0, 0);
        settle; check_bus("end_idle", 0, 0, 0, 0, 8'h00, 32'h0);

        tick; tick; settle;
        chk("q0_drained", DW'(q0.size()), 32'd0);
        chk("q1_drained", DW'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the single-port synchronous data memory between two requesters:
  - port 0: pipeline MEM stage.
  - port 1: loader/debug port.
- Uses round-robin arbitration plus an optional bounded lock for bursts.
- Drives the memory's MemWrite/MemRead/address/write_data directly.
- The memory returns read data one cycle after the access; the arbiter routes it to the requester that issued the read.

## Interface

- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 8, word address width (memory holds 2^ADDR_WIDTH words)
- MAX_BURST, 16, maximum cycles a lock may be held; must be ≥1
- clk  input  1  clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- pN_valid  input  1  requester N (N=0,1) has a request
- pN_ready  output  1  request accepted this cycle (valid && ready)
- pN_we  input  1  1 = write, 0 = read
- pN_addr  input  ADDR_WIDTH  word address
- pN_wdata  input  DATA_WIDTH  write data
- pN_lock  input  1  request or keep exclusive ownership
- pN_rvalid  output  1  read data valid for requester N
- pN_rdata  output  DATA_WIDTH  read data
- mem_MemWrite  output  1  memory write enable
- mem_MemRead  output  1  memory read enable
- mem_address  output  ADDR_WIDTH  memory address
- mem_write_data  output  DATA_WIDTH  memory write data
- mem_read_data  input  DATA_WIDTH  memory registered read data

## Operation

- State machine: ARB, LOCK0, LOCK1. Other state:
  - rr_ptr: requester favored on contention.
  - burst_cnt, width $clog2(MAX_BURST+1).
  - rsp_valid and rsp_id: one-entry response tracker.
- **ARB state**
  - Only one requester valid: it is granted.
  - Both valid: requester rr_ptr is granted.
  - After any grant: rr_ptr ← the other requester.
  - Granted beat with pN_lock=1: next state LOCKN, burst_cnt ← 1.
- **LOCKN state**
  - Only N can be granted; the other port's ready is 0.
  - burst_cnt increments every cycle in LOCKN, idle or not.
  - Exit to ARB at the next edge if pN_lock=0 or burst_cnt reaches MAX_BURST. On exit, rr_ptr ← the other requester.
  - The cycle in which pN_lock=0 is still exclusive to N.
- **Memory drive** (combinational from the grant)
  - Grant of a write: mem_MemWrite=1, mem_MemRead=0.
  - Grant of a read: mem_MemRead=1, mem_MemWrite=0.
  - Address and data are muxed from the granted port.
  - No grant: both enables are 0 and address/data are 0.
- **Read response**
  - An accepted read sets rsp_valid=1 and rsp_id=N for the next cycle.
  - That cycle: pN_rvalid=1 and pN_rdata=mem_read_data. The other port's rvalid=0 and its rdata=0.
- Writes produce no response.
- A read and a write on the same address in consecutive cycles: the read returns the value present at the read's edge. Write-then-read returns the new value.

## Timing

- Reset values:
  - State ARB, rr_ptr=0, burst_cnt=0, rsp_valid=0.
  - All ready, rvalid and mem enables 0; rdata 0.
- pN_ready is combinational from the valid inputs and the state. There is no combinational path from ready to valid.
- A requester may hold valid and change nothing until ready.
- Throughput: one access per cycle, back-to-back.
- Read latency: rvalid exactly 1 cycle after acceptance.
- Reset asserted mid-burst or with a read in flight:
  - Next cycle: state ARB, and the pending rvalid is suppressed (0).
  - No memory enable is asserted during the reset cycle.
- MAX_BURST=1: a lock lasts exactly one extra exclusive cycle and then returns to ARB.

## Structure

- Shared package/include dmem_arb_pkg holds:
  - State encoding constants: ARB=2'd0, LOCK0=2'd1, LOCK1=2'd2.
  - Requester ids: REQ_PIPE=1'b0, REQ_LOAD=1'b1.
- No sub-module is needed. Grant logic, FSM and the response tracker live in dmem_arbiter.
- The data memory is instantiated alongside dmem_arbiter by the parent, not inside it.

## Test plan

- **Reset:** hold reset 2 cycles → all outputs 0; after release with no valid, no mem enable.
- **Contention:** p0 and p1 both write from reset → p0 granted first, then p1 next cycle. Then p0 read 0x10 and p1 read 0x20 together → grants alternate, and each rvalid arrives 1 cycle later on the correct port with the correct data.
- **Write then read:** p0 write 0x10=0xDEADBEEF, next cycle p0 read 0x10 → p0_rvalid=1 with 0xDEADBEEF two cycles after the write; p1_rvalid stays 0.
- **Lock:** p1 lock burst of 4 writes to 0x00–0x03 while p0_valid held high → p0_ready=0 for the whole burst. p0 is granted in the first cycle after the exit, with pN_lock=0 seen in the cycle after the 4th beat.
- **Lock timeout:** MAX_BURST=16, p1_lock held high forever → forced exit after 16 cycles in LOCK1; p0 then granted, and p1 waits for its round-robin turn.
- **Reset mid-operation:** reset asserted the cycle after a p1 read is accepted → p1_rvalid=0 next cycle, state ARB, rr_ptr=0.
